// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture engine.
package la_pkg;

    localparam int LA_ST_W      = 3;
    localparam int LA_MIN_DEPTH = 4;

    typedef enum logic [LA_ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4,
        ST_READ = 3'd5
    } la_state_e;

endpackage

// File: rtl/la_ring_ram.sv
// Simple dual-port sample buffer with a registered read port (1-cycle latency),
// shaped so the array maps onto block RAM.
module la_ring_ram #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one sample per cycle while capturing.
    // NOTE: the array has no reset -- a reset loop would stop block-RAM inference,
    // and sequential state is always assigned with <= so all registers update together.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: output register only advances on re, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: ring-buffer sampling with a pre-trigger window,
// mask/value trigger, and valid/ready readout of the frozen buffer.
// Optional macro LA_EDGE_TRIG_EN: trigger on a mismatch-to-match edge inside WAIT
// instead of on the match level.
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W   = 48,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] probe_i,
    input  logic              arm_i,
    input  logic              force_trig_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic              rd_req_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [LA_ST_W-1:0] state_o,
    output logic              triggered_o,
    output logic              done_o
);

    // Last PRE fill count before moving to WAIT; PRE_TRIG = 0 leaves after one cycle.
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   RD_WORDS  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   RD_LAST   = (ADDR_W+1)'(DEPTH - 1);

    la_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr, fill_cnt, post_cnt, trig_ptr, rd_ptr;
    logic [ADDR_W:0]   rd_cnt;
    logic              we, re, do_arm, do_trig, do_rd_start;
    logic              match, trig_hit;
    logic              rd_valid_q, rd_last_q;
    logic [DATA_W-1:0] ram_rdata;

    assign match = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;

`ifdef LA_EDGE_TRIG_EN
    logic match_q;

    // Previous-cycle match. Seeded high on WAIT entry so a value already matching when
    // WAIT begins cannot fire; only a mismatch-to-match edge seen inside WAIT does.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (state_q == ST_PRE && state_d == ST_WAIT) begin
            match_q <= 1'b1;
        end else if (state_q == ST_WAIT) begin
            match_q <= match;
        end
    end

    assign trig_hit = (match & ~match_q) | force_trig_i;
`else
    assign trig_hit = match | force_trig_i;
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        we          = 1'b0;
        re          = 1'b0;
        do_arm      = 1'b0;
        do_trig     = 1'b0;
        do_rd_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    do_arm  = 1'b1;
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                we = 1'b1;
                if (fill_cnt == PRE_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                we = 1'b1;
                if (trig_hit) begin
                    do_trig = 1'b1;
                    state_d = (POST_LOAD == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                we = 1'b1;
                if (post_cnt == PTR_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm_i) begin
                    do_arm  = 1'b1;
                    state_d = ST_PRE;
                end else if (rd_req_i) begin
                    do_rd_start = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                // Fetch the next word whenever the output slot is empty or being drained.
                re = (rd_cnt != RD_WORDS) && (!rd_valid_q || rd_ready_i);
                if (rd_valid_q && rd_ready_i && rd_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture-side pointers, counters and the trigger flag.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            trig_ptr    <= '0;
            triggered_o <= 1'b0;
        end else begin
            if (do_arm) begin
                wr_ptr      <= '0;
                fill_cnt    <= '0;
                triggered_o <= 1'b0;
            end else if (we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (state_q == ST_PRE) begin
                fill_cnt <= fill_cnt + PTR_ONE;
            end
            if (do_trig) begin
                trig_ptr    <= wr_ptr;
                triggered_o <= 1'b1;
                post_cnt    <= POST_LOAD;
            end else if (state_q == ST_POST) begin
                post_cnt <= post_cnt - PTR_ONE;
            end
        end
    end

    // Readout pointer, word count and the output valid/last flags.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (do_rd_start) begin
                rd_ptr <= trig_ptr - PRE_OFS;
                rd_cnt <= '0;
            end else if (re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (re) begin
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_cnt == RD_LAST);
            end else if (rd_ready_i) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

    la_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (probe_i),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    // The RAM output register is not reset, so gate it to keep idle data at zero.
    assign rd_data_o  = rd_valid_q ? ram_rdata : '0;
    assign state_o    = state_q;
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=8, DEPTH=16, PRE_TRIG=4), plus a
// PRE_TRIG=0 instance for the force/boundary case.
module tb_la_capture_core;
    import la_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] probe, trig_mask, trig_value;
    logic       arm, force_trig, rd_req, rd_ready;
    logic       rd_valid, rd_last, triggered, done;
    logic [7:0] rd_data;
    logic [2:0] state;

    logic       arm0, force0, rd_req0;
    logic       rd_valid0, rd_last0, triggered0, done0;
    logic [7:0] rd_data0;
    logic [2:0] state0;

    int n_pass  = 0;
    int n_total = 0;

    la_capture_core #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(4)) u_dut (
        .sys_clk      (clk),
        .rst          (rst),
        .probe_i      (probe),
        .arm_i        (arm),
        .force_trig_i (force_trig),
        .trig_mask_i  (trig_mask),
        .trig_value_i (trig_value),
        .rd_req_i     (rd_req),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data),
        .rd_last_o    (rd_last),
        .state_o      (state),
        .triggered_o  (triggered),
        .done_o       (done)
    );

    la_capture_core #(.DATA_W(8), .DEPTH(16), .PRE_TRIG(0)) u_dut0 (
        .sys_clk      (clk),
        .rst          (rst),
        .probe_i      (probe),
        .arm_i        (arm0),
        .force_trig_i (force0),
        .trig_mask_i  (trig_mask),
        .trig_value_i (trig_value),
        .rd_req_i     (rd_req0),
        .rd_valid_o   (rd_valid0),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data0),
        .rd_last_o    (rd_last0),
        .state_o      (state0),
        .triggered_o  (triggered0),
        .done_o       (done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        check({tag, "_trig"},  32'(triggered), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_valid"}, 32'(rd_valid), 0);
        check({tag, "_last"},  32'(rd_last), 0);
        check({tag, "_data"},  32'(rd_data), 0);
    endtask

    // Arm, drive probe = (start + i) % modv, expect the trigger on sample exp_idx,
    // then run POST (or stop after post_stop POST cycles).
    task automatic run_capture(input int start, input int modv, input logic [7:0] tval,
                               input int exp_idx, input bit force_pre, input int post_stop);
        int i;
        int n;
        trig_mask  = 8'hFF;
        trig_value = tval;
        probe      = 8'(start);
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_state", 32'(state), 32'(ST_PRE));
        check("arm_trig_clr", 32'(triggered), 0);
        i = 0;
        while (!triggered && i < 100) begin
            i++;
            probe      = 8'((start + i) % modv);
            force_trig = force_pre && (i == 3);
            tick();
            if (i == 4) begin
                check("pre_len_state", 32'(state), 32'(ST_WAIT));
                check("pre_no_trig", 32'(triggered), 0);
            end
        end
        force_trig = 1'b0;
        check("trig_idx", i, exp_idx);
        check("trig_state", 32'(state), 32'(ST_POST));
        n = 0;
        while (!done && n < 50) begin
            if (n == post_stop) return;
            i++;
            probe = 8'((start + i) % modv);
            tick();
            n++;
        end
        check("post_len", n, 11);
        check("done_state", 32'(state), 32'(ST_DONE));
    endtask

    // Read the buffer; expected word k is (first + k) % modv.
    task automatic read_words(input logic [7:0] first, input int modv, input bit rnd,
                              input int stop_after);
        int  k;
        int  cyc;
        bit  stalled;
        k       = 0;
        cyc     = 0;
        stalled = 1'b0;
        rd_ready = 1'b0;
        rd_req   = 1'b1;
        tick();
        rd_req = 1'b0;
        check("rd_lat1_valid", 32'(rd_valid), 0);
        check("rd_state", 32'(state), 32'(ST_READ));
        tick();
        check("rd_lat2_valid", 32'(rd_valid), 1);
        for (int c = 0; c < 200 && k < 16; c++) begin
            if (stalled) check("rd_hold_valid", 32'(rd_valid), 1);
            if (rd_valid) begin
                cyc++;
                check("rd_data", 32'(rd_data), 32'((32'(first) + k) % modv));
                check("rd_last", 32'(rd_last), 32'(k == 15));
            end
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled  = rd_valid && !rd_ready;
            if (rd_valid && rd_ready) k++;
            tick();
            if (k == stop_after) begin
                rd_ready = 1'b0;
                return;
            end
        end
        rd_ready = 1'b0;
        check("rd_count", k, 16);
        if (!rnd) check("rd_thruput", cyc, 16);
        check("rd_end_valid", 32'(rd_valid), 0);
        check("rd_end_state", 32'(state), 32'(ST_IDLE));
    endtask

    initial begin
        int k;
        int n;
        rst        = 1'b1;
        probe      = '0;
        trig_mask  = '0;
        trig_value = '0;
        arm        = 1'b0;
        force_trig = 1'b0;
        rd_req     = 1'b0;
        rd_ready   = 1'b0;
        arm0       = 1'b0;
        force0     = 1'b0;
        rd_req0    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");
        check("reset_state0", 32'(state0), 32'(ST_IDLE));

        // rd_req in IDLE is ignored.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("idle_rdreq", 32'(state), 32'(ST_IDLE));

        // Level trigger on 0x0A with an incrementing probe; full-rate readout.
        run_capture(0, 256, 8'h0A, 10, 1'b0, -1);
        read_words(8'h06, 256, 1'b0, -1);

        // Early match (0x01 in the 2nd PRE cycle) and force in PRE are ignored;
        // the trigger is the 0x01 after the 0x20 wrap. Random backpressure readout.
        run_capture(32'h1F, 32'h20, 8'h01, 34, 1'b1, -1);
        read_words(8'h1D, 32'h20, 1'b1, -1);

        // PRE_TRIG = 0: force on the first WAIT cycle, word 0 is the trigger sample.
        trig_mask  = 8'hFF;
        trig_value = 8'hFF;
        probe      = 8'h40;
        arm0       = 1'b1;
        tick();
        arm0  = 1'b0;
        probe = 8'h50;
        tick();
        check("f_wait_state", 32'(state0), 32'(ST_WAIT));
        check("f_no_trig", 32'(triggered0), 0);
        probe  = 8'h60;
        force0 = 1'b1;
        tick();
        force0 = 1'b0;
        check("f_trig", 32'(triggered0), 1);
        check("f_post_state", 32'(state0), 32'(ST_POST));
        n = 0;
        while (!done0 && n < 50) begin
            n++;
            probe = 8'(8'h60 + n);
            tick();
        end
        check("f_post_len", n, 15);
        rd_req0 = 1'b1;
        tick();
        rd_req0 = 1'b0;
        tick();
        check("f_rd_valid", 32'(rd_valid0), 1);
        rd_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 16; c++) begin
            if (rd_valid0) begin
                check("f_data", 32'(rd_data0), 32'(8'h60 + k));
                check("f_last", 32'(rd_last0), 32'(k == 15));
                k++;
            end
            tick();
        end
        rd_ready = 1'b0;
        check("f_count", k, 16);
        check("f_end_valid", 32'(rd_valid0), 0);

        // Reset in POST, then in READ after 5 words, then a clean capture.
        run_capture(0, 256, 8'h0A, 10, 1'b0, 3);
        check("mid_post_state", 32'(state), 32'(ST_POST));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_post");
        run_capture(0, 256, 8'h0A, 10, 1'b0, -1);
        read_words(8'h06, 256, 1'b0, 5);
        check("mid_read_state", 32'(state), 32'(ST_READ));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_read");
        run_capture(32'h30, 256, 8'h3A, 10, 1'b0, -1);
        read_words(8'h36, 256, 1'b0, -1);

`ifdef LA_EDGE_TRIG_EN
        // Held match never fires; a 0x0B -> 0x0A transition fires on the 0x0A cycle.
        trig_mask  = 8'hFF;
        trig_value = 8'h0A;
        probe      = 8'h0A;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("edge_held_state", 32'(state), 32'(ST_WAIT));
        check("edge_held", 32'(triggered), 0);
        probe = 8'h0B;
        tick();
        check("edge_mismatch", 32'(triggered), 0);
        probe = 8'h0A;
        tick();
        check("edge_fire", 32'(triggered), 1);
        check("edge_state", 32'(state), 32'(ST_POST));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
